sd_power_manager: RTL and testbench

SD_POWER_MANAGER -- requirements
Module: sd_power_manager

---
 rtl/sd_pwr_pkg.sv | 39 +++
 rtl/sd_pm_timer.sv | 27 ++
 rtl/sd_power_manager.sv | 150 +++++++++++++++
 tb/tb_sd_power_manager.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pwr_pkg.sv
// Shared power-management definitions used by the SD power manager and the
// SD power controller: power-state codes, the manager state enum and helpers.
package sd_pwr_pkg;

  typedef enum logic [1:0] {
    PWR_ACTIVE = 2'b00,
    PWR_IDLE   = 2'b01,
    PWR_SLEEP  = 2'b10,
    PWR_DOWN   = 2'b11
  } pwr_state_e;

  typedef enum logic [3:0] {
    PM_PDOWN,
    PM_WAKE,
    PM_ACTIVE,
    PM_IDLE,
    PM_SLEEP,
    PM_VSW_GATE,
    PM_VSW_SETTLE,
    PM_VSW_RESUME,
    PM_FAULT
  } pm_state_e;

  // Power-state code presented to the power controller for each manager state
  function automatic pwr_state_e pm_power_code(pm_state_e s);
    case (s)
      PM_IDLE:             return PWR_IDLE;
      PM_SLEEP:            return PWR_SLEEP;
      PM_PDOWN, PM_FAULT:  return PWR_DOWN;
      default:             return PWR_ACTIVE;
    endcase
  endfunction

  // True while a voltage switch is in progress
  function automatic logic pm_is_vsw(pm_state_e s);
    return (s == PM_VSW_GATE) || (s == PM_VSW_SETTLE) || (s == PM_VSW_RESUME);
  endfunction

endpackage

// File: rtl/sd_pm_timer.sv
// 16-bit saturating cycle counter with synchronous clear, count enable and a
// registered-count >= limit compare, used for inactivity, gating and timeouts.
module sd_pm_timer (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        reached
);

  logic [15:0] count;

  // Count enabled cycles from zero, holding at all-ones instead of wrapping
  always_ff @(posedge PCLK_i) begin
    if (!PRESETn_i) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign reached = (count >= limit);

endmodule

// File: rtl/sd_power_manager.sv
// SD card power manager: sequences power-down, wake, active/idle/sleep and
// clock-gated voltage switching, and drives the external power controller.
module sd_power_manager
  import sd_pwr_pkg::*;
#(
  parameter int VSW_GATE_CYCLES = 8,
  parameter int PGOOD_TIMEOUT   = 1024
) (
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        activity_i,
  input  logic        sw_wake_i,
  input  logic        sw_pd_req_i,
  input  logic [15:0] idle_timeout_i,
  input  logic [15:0] sleep_timeout_i,
  input  logic [3:0]  vsel_req_i,
  input  logic        vsel_req_valid_i,
  input  logic        power_good_i,
  input  logic        power_fault_i,
  output logic [1:0]  power_state_o,
  output logic [3:0]  voltage_sel_o,
  output logic        clk_enable_o,
  output logic        vsel_busy_o,
  output logic        vsel_done_o,
  output logic        vsel_err_o,
  output logic        fault_irq_o
);

  // Counts start at zero on state entry, so "last" values make a state last
  // exactly the parameterised number of cycles.
  localparam logic [15:0] GATE_LAST  = 16'(VSW_GATE_CYCLES - 1);
  localparam logic [15:0] PGOOD_LAST = 16'(PGOOD_TIMEOUT - 1);

  pm_state_e   state_q, state_n;
  logic [3:0]  vsel_code_q, vsel_code_n;
  logic [3:0]  voltage_sel_n;
  logic        done_n, err_n;
  logic        state_change;
  logic        vsel_accept;
  logic [15:0] inact_limit, wait_limit;
  logic        inact_reached, wait_reached;
  logic        inact_enable, wait_enable;

  assign state_change = (state_n != state_q);
  assign vsel_accept  = vsel_req_valid_i && (state_q == PM_ACTIVE) &&
                        !power_fault_i && !sw_pd_req_i;

  assign inact_enable = (state_q == PM_ACTIVE) || (state_q == PM_IDLE);
  assign inact_limit  = (state_q == PM_IDLE) ? sleep_timeout_i : idle_timeout_i;
  assign wait_enable  = (state_q == PM_WAKE) || pm_is_vsw(state_q);
  assign wait_limit   = ((state_q == PM_WAKE) || (state_q == PM_VSW_SETTLE)) ?
                        PGOOD_LAST : GATE_LAST;

  sd_pm_timer u_inact_timer (
    .PCLK_i    (PCLK_i),
    .PRESETn_i (PRESETn_i),
    .clear     (activity_i || state_change),
    .enable    (inact_enable),
    .limit     (inact_limit),
    .reached   (inact_reached)
  );

  sd_pm_timer u_wait_timer (
    .PCLK_i    (PCLK_i),
    .PRESETn_i (PRESETn_i),
    .clear     (state_change),
    .enable    (wait_enable),
    .limit     (wait_limit),
    .reached   (wait_reached)
  );

  // Next state and next output values: fault beats power-down beats a switch
  // request beats the activity/timeout transitions.
  always_comb begin
    state_n       = state_q;
    vsel_code_n   = vsel_code_q;
    voltage_sel_n = voltage_sel_o;
    done_n        = 1'b0;
    err_n         = vsel_req_valid_i && !vsel_accept;
    if (power_fault_i && (state_q != PM_FAULT)) begin
      state_n = PM_FAULT;
    end else if (sw_pd_req_i && (state_q != PM_FAULT)) begin
      state_n = PM_PDOWN;
    end else if (vsel_accept) begin
      state_n     = PM_VSW_GATE;
      vsel_code_n = vsel_req_i;
    end else begin
      case (state_q)
        PM_PDOWN: if (sw_wake_i) state_n = PM_WAKE;
        PM_WAKE: begin
          if (power_good_i)      state_n = PM_ACTIVE;
          else if (wait_reached) state_n = PM_FAULT;
        end
        PM_ACTIVE: begin
          if ((idle_timeout_i != 16'd0) && inact_reached && !activity_i)
            state_n = PM_IDLE;
        end
        PM_IDLE: begin
          if (activity_i) state_n = PM_ACTIVE;
          else if ((sleep_timeout_i != 16'd0) && inact_reached) state_n = PM_SLEEP;
        end
        PM_SLEEP: if (activity_i || sw_wake_i) state_n = PM_WAKE;
        PM_VSW_GATE: begin
          if (wait_reached) begin
            state_n       = PM_VSW_SETTLE;
            voltage_sel_n = vsel_code_q;
          end
        end
        PM_VSW_SETTLE: begin
          if (power_good_i)      state_n = PM_VSW_RESUME;
          else if (wait_reached) state_n = PM_FAULT;
        end
        PM_VSW_RESUME: begin
          if (wait_reached) begin
            state_n = PM_ACTIVE;
            done_n  = 1'b1;
          end
        end
        PM_FAULT: if (sw_wake_i && !power_fault_i) state_n = PM_WAKE;
        default:  state_n = PM_PDOWN;
      endcase
    end
  end

  // State register with outputs registered from the next state
  always_ff @(posedge PCLK_i) begin
    if (!PRESETn_i) begin
      state_q       <= PM_PDOWN;
      vsel_code_q   <= 4'h0;
      voltage_sel_o <= 4'h0;
      power_state_o <= PWR_DOWN;
      clk_enable_o  <= 1'b0;
      vsel_busy_o   <= 1'b0;
      vsel_done_o   <= 1'b0;
      vsel_err_o    <= 1'b0;
      fault_irq_o   <= 1'b0;
    end else begin
      state_q       <= state_n;
      vsel_code_q   <= vsel_code_n;
      voltage_sel_o <= voltage_sel_n;
      power_state_o <= pm_power_code(state_n);
      clk_enable_o  <= (state_n == PM_ACTIVE);
      vsel_busy_o   <= pm_is_vsw(state_n);
      vsel_done_o   <= done_n;
      vsel_err_o    <= err_n;
      fault_irq_o   <= (state_n == PM_FAULT);
    end
  end

endmodule

// File: tb/tb_sd_power_manager.sv
// Scoreboard bench for sd_power_manager: each stimulus step queues the output
// values expected on a given future cycle; a negedge monitor compares them.
module tb_sd_power_manager;

  localparam int F_PS   = 0;
  localparam int F_CLK  = 1;
  localparam int F_VSEL = 2;
  localparam int F_BUSY = 3;
  localparam int F_DONE = 4;
  localparam int F_ERR  = 5;
  localparam int F_FIRQ = 6;

  logic        PCLK_i;
  logic        PRESETn_i;
  logic        activity_i;
  logic        sw_wake_i;
  logic        sw_pd_req_i;
  logic [15:0] idle_timeout_i;
  logic [15:0] sleep_timeout_i;
  logic [3:0]  vsel_req_i;
  logic        vsel_req_valid_i;
  logic        power_good_i;
  logic        power_fault_i;
  logic [1:0]  power_state_o;
  logic [3:0]  voltage_sel_o;
  logic        clk_enable_o;
  logic        vsel_busy_o;
  logic        vsel_done_o;
  logic        vsel_err_o;
  logic        fault_irq_o;

  int    cyc = 0;
  int    nChecks = 0;
  int    nPassed = 0;
  int    qCyc[$];
  int    qField[$];
  int    qExp[$];
  string qTag[$];

  sd_power_manager #(.VSW_GATE_CYCLES(8), .PGOOD_TIMEOUT(1024)) dut (
    .PCLK_i           (PCLK_i),
    .PRESETn_i        (PRESETn_i),
    .activity_i       (activity_i),
    .sw_wake_i        (sw_wake_i),
    .sw_pd_req_i      (sw_pd_req_i),
    .idle_timeout_i   (idle_timeout_i),
    .sleep_timeout_i  (sleep_timeout_i),
    .vsel_req_i       (vsel_req_i),
    .vsel_req_valid_i (vsel_req_valid_i),
    .power_good_i     (power_good_i),
    .power_fault_i    (power_fault_i),
    .power_state_o    (power_state_o),
    .voltage_sel_o    (voltage_sel_o),
    .clk_enable_o     (clk_enable_o),
    .vsel_busy_o      (vsel_busy_o),
    .vsel_done_o      (vsel_done_o),
    .vsel_err_o       (vsel_err_o),
    .fault_irq_o      (fault_irq_o)
  );

  initial begin
    PCLK_i = 1'b0;
    forever #5 PCLK_i = ~PCLK_i;
  end

  always @(posedge PCLK_i) cyc <= cyc + 1;

  function automatic int getField(int f);
    case (f)
      F_PS:    return int'(power_state_o);
      F_CLK:   return int'(clk_enable_o);
      F_VSEL:  return int'(voltage_sel_o);
      F_BUSY:  return int'(vsel_busy_o);
      F_DONE:  return int'(vsel_done_o);
      F_ERR:   return int'(vsel_err_o);
      default: return int'(fault_irq_o);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed == expected) nPassed++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
  endtask

  // Queue an expected output value for the cycle 'offset' edges from now
  task automatic applyStimulus(input int offset, input string tag, input int field, input int value);
    qCyc.push_back(cyc + offset);
    qTag.push_back(tag);
    qField.push_back(field);
    qExp.push_back(value);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK_i);
    #1;
  endtask

  always @(negedge PCLK_i) begin
    for (int i = qCyc.size() - 1; i >= 0; i--) begin
      if (qCyc[i] == cyc) begin
        checkOutput(qTag[i], getField(qField[i]), qExp[i]);
        qCyc.delete(i);
        qTag.delete(i);
        qField.delete(i);
        qExp.delete(i);
      end
    end
  end

  initial begin
    PRESETn_i = 1'b0; activity_i = 1'b0; sw_wake_i = 1'b0; sw_pd_req_i = 1'b0;
    idle_timeout_i = 16'd0; sleep_timeout_i = 16'd0; vsel_req_i = 4'h0;
    vsel_req_valid_i = 1'b0; power_good_i = 1'b0; power_fault_i = 1'b0;

    // Reset values
    tick(1);
    applyStimulus(1, "rst_pstate", F_PS, 3);
    applyStimulus(1, "rst_clk", F_CLK, 0);
    applyStimulus(1, "rst_vsel", F_VSEL, 0);
    applyStimulus(1, "rst_busy", F_BUSY, 0);
    applyStimulus(1, "rst_firq", F_FIRQ, 0);
    tick(1);
    PRESETn_i = 1'b1;
    tick(2);

    // Wake with power_good after five WAKE cycles
    sw_wake_i = 1'b1;
    applyStimulus(1, "wake_pstate", F_PS, 0);
    applyStimulus(1, "wake_clk", F_CLK, 0);
    tick(1);
    sw_wake_i = 1'b0;
    tick(4);
    applyStimulus(0, "wake5_clk", F_CLK, 0);
    power_good_i = 1'b1;
    applyStimulus(1, "active_pstate", F_PS, 0);
    applyStimulus(1, "active_clk", F_CLK, 1);
    tick(1);

    // Idle after 10 inactive cycles, sleep 20 later, activity wakes
    idle_timeout_i = 16'd10;
    sleep_timeout_i = 16'd20;
    applyStimulus(10, "pre_idle", F_PS, 0);
    applyStimulus(11, "idle_pstate", F_PS, 1);
    applyStimulus(11, "idle_clk", F_CLK, 0);
    applyStimulus(31, "pre_sleep", F_PS, 1);
    applyStimulus(32, "sleep_pstate", F_PS, 2);
    tick(32);
    activity_i = 1'b1;
    applyStimulus(1, "sleep_wake_ps", F_PS, 0);
    applyStimulus(1, "sleep_wake_clk", F_CLK, 0);
    applyStimulus(2, "rewake_clk", F_CLK, 1);
    tick(1);
    activity_i = 1'b0;
    tick(1);

    // Voltage switch to code 1 with power_good held high
    idle_timeout_i = 16'd0;
    sleep_timeout_i = 16'd0;
    vsel_req_i = 4'h1;
    vsel_req_valid_i = 1'b1;
    applyStimulus(1, "vsw_busy", F_BUSY, 1);
    applyStimulus(1, "vsw_gate_clk", F_CLK, 0);
    applyStimulus(1, "vsw_no_err", F_ERR, 0);
    applyStimulus(8, "vsw_gate_vsel", F_VSEL, 0);
    applyStimulus(9, "vsw_new_vsel", F_VSEL, 1);
    applyStimulus(17, "vsw_resume_clk", F_CLK, 0);
    applyStimulus(17, "vsw_resume_done", F_DONE, 0);
    applyStimulus(18, "vsw_done", F_DONE, 1);
    applyStimulus(18, "vsw_done_clk", F_CLK, 1);
    applyStimulus(18, "vsw_done_busy", F_BUSY, 0);
    applyStimulus(19, "vsw_done_pulse", F_DONE, 0);
    tick(1);
    vsel_req_valid_i = 1'b0;
    tick(18);

    // Lowering the idle timeout below the count takes effect next cycle
    idle_timeout_i = 16'd1000;
    tick(5);
    applyStimulus(0, "pre_lower", F_PS, 0);
    idle_timeout_i = 16'd3;
    applyStimulus(1, "lowered_idle", F_PS, 1);
    tick(1);

    // Switch request outside ACTIVE is rejected
    vsel_req_i = 4'h5;
    vsel_req_valid_i = 1'b1;
    applyStimulus(1, "err_pulse", F_ERR, 1);
    applyStimulus(1, "err_vsel", F_VSEL, 1);
    applyStimulus(1, "err_pstate", F_PS, 1);
    applyStimulus(2, "err_clear", F_ERR, 0);
    tick(1);
    vsel_req_valid_i = 1'b0;
    tick(1);

    // Settle timeout with power_good low leads to FAULT
    activity_i = 1'b1;
    applyStimulus(1, "idle_act_clk", F_CLK, 1);
    tick(1);
    activity_i = 1'b0;
    idle_timeout_i = 16'd0;
    power_good_i = 1'b0;
    vsel_req_i = 4'h2;
    vsel_req_valid_i = 1'b1;
    applyStimulus(9, "settle_vsel", F_VSEL, 2);
    applyStimulus(1032, "settle_last_firq", F_FIRQ, 0);
    applyStimulus(1032, "settle_last_busy", F_BUSY, 1);
    applyStimulus(1033, "to_fault_firq", F_FIRQ, 1);
    applyStimulus(1033, "to_fault_ps", F_PS, 3);
    applyStimulus(1033, "to_fault_busy", F_BUSY, 0);
    tick(1);
    vsel_req_valid_i = 1'b0;
    tick(1032);

    // FAULT holds on sw_wake while power_fault is high, exits once it drops
    power_fault_i = 1'b1;
    sw_wake_i = 1'b1;
    applyStimulus(1, "fault_hold", F_FIRQ, 1);
    applyStimulus(1, "fault_hold_ps", F_PS, 3);
    tick(1);
    power_fault_i = 1'b0;
    applyStimulus(1, "fault_exit", F_FIRQ, 0);
    applyStimulus(1, "fault_exit_ps", F_PS, 0);
    tick(1);
    sw_wake_i = 1'b0;

    // Fault wins over a simultaneous power-down request
    power_fault_i = 1'b1;
    sw_pd_req_i = 1'b1;
    applyStimulus(1, "pd_vs_fault_ps", F_PS, 3);
    applyStimulus(1, "pd_vs_fault_irq", F_FIRQ, 1);
    tick(1);
    power_fault_i = 1'b0;
    sw_pd_req_i = 1'b0;

    // Power-down during a switch aborts it with no done pulse
    sw_wake_i = 1'b1;
    power_good_i = 1'b1;
    tick(1);
    sw_wake_i = 1'b0;
    tick(1);
    vsel_req_i = 4'h7;
    vsel_req_valid_i = 1'b1;
    applyStimulus(1, "abort_busy_on", F_BUSY, 1);
    tick(1);
    vsel_req_valid_i = 1'b0;
    tick(3);
    sw_pd_req_i = 1'b1;
    applyStimulus(1, "abort_ps", F_PS, 3);
    applyStimulus(1, "abort_vsel", F_VSEL, 2);
    applyStimulus(1, "abort_busy", F_BUSY, 0);
    applyStimulus(1, "abort_done", F_DONE, 0);
    applyStimulus(10, "abort_no_done", F_DONE, 0);
    applyStimulus(10, "abort_stay_pd", F_PS, 3);
    tick(1);
    sw_pd_req_i = 1'b0;
    tick(11);

    for (int n = 0; n < 50 && qCyc.size() != 0; n++) tick(1);
    checkOutput("sb_drain", qCyc.size(), 0);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
